// File: rtl/division.sv
// Sequential restoring divider: one quotient bit per clock, divide-by-zero flagged on o_error.
// Build option DIVISION_ZERO_SAT_EN: a divide-by-zero returns an all-ones quotient instead of 0.
module division #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_error,
  output logic [1:0]       o_state
);

  // Handshake: i_start is taken on any rising edge where o_busy=0 (IDLE or DONE);
  // o_done pulses for one cycle when o_quotient/o_remainder/o_error become valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef DIVISION_ZERO_SAT_EN
  localparam logic [WIDTH-1:0] ZERO_DIV_Q = '1;
`else
  localparam logic [WIDTH-1:0] ZERO_DIV_Q = '0;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] dvd_n;
  logic             q_bit;
  logic             accept;
  logic             last;

  // dvd doubles as the quotient register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
  always_comb begin
    accept = i_start && (state != CALC);
    last   = (cnt == CW'(WIDTH - 1));
    trial  = {rem, dvd[WIDTH-1]};
    q_bit  = 1'b0;
    rem_n  = trial[WIDTH-1:0];
    if (trial >= {1'b0, dvs}) begin
      q_bit = 1'b1;
      rem_n = trial[WIDTH-1:0] - dvs;
    end
    dvd_n = (dvd << 1) | WIDTH'(q_bit);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) state_n = (i_divisor != '0) ? CALC : DONE;
      end
      CALC:    if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_error     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == CALC) begin
        rem <= rem_n;
        dvd <= dvd_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          o_quotient  <= dvd_n;
          o_remainder <= rem_n;
        end
      end else if (accept) begin
        if (i_divisor != '0) begin
          dvd     <= i_dividend;
          dvs     <= i_divisor;
          rem     <= '0;
          cnt     <= '0;
          o_error <= 1'b0;
        end else begin
          o_error     <= 1'b1;
          o_quotient  <= ZERO_DIV_Q;
          o_remainder <= i_dividend;
        end
      end
    end
  end

  assign o_busy  = (state == CALC);
  assign o_done  = (state == DONE);
  assign o_state = state;

endmodule

// File: tb/tb_division.sv
// Self-checking bench for division: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_division;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start8, busy8, done8, err8;
  logic [W-1:0] a8, b8, q8, r8;
  logic [1:0]   st8;
  logic         start1, busy1, done1, err1;
  logic [0:0]   a1, b1, q1, r1;
  logic [1:0]   st1;

  division #(.WIDTH(W)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_dividend(a8), .i_divisor(b8),
    .o_busy(busy8), .o_done(done8), .o_quotient(q8), .o_remainder(r8),
    .o_error(err8), .o_state(st8)
  );

  division #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_dividend(a1), .i_divisor(b1),
    .o_busy(busy1), .o_done(done1), .o_quotient(q1), .o_remainder(r1),
    .o_error(err1), .o_state(st1)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference: plain unsigned / and %, with the divide-by-zero convention of the build.
  function automatic void model8(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic e);
    if (b == 0) begin
`ifdef DIVISION_ZERO_SAT_EN
      q = {W{1'b1}};
`else
      q = '0;
`endif
      r = a;
      e = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      e = 1'b0;
    end
  endfunction

  // Starts one WIDTH=8 division and watches a fixed window; lat is the cycle count
  // (cycle 1 = first sample after the accepting edge) of the first o_done, 0 if none.
  task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b,
                      output logic [W-1:0] q, output logic [W-1:0] r, output logic e,
                      output int lat, output int busy_n, output int done_n, output logic held);
    q = '0; r = '0; e = 1'b0; lat = 0; busy_n = 0; done_n = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk);
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (lat == 0) begin
          lat = i; q = q8; r = r8; e = err8;
        end
      end
      if (i == 1) begin
        start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom);
      end
    end
    held = (q8 === q) && (r8 === r) && (err8 === e);
  endtask

  task automatic run1(input logic a, input logic b, output logic q, output logic r,
                      output logic e, output int lat);
    q = 1'b0; r = 1'b0; e = 1'b0; lat = 0;
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done1 && lat == 0) begin
        lat = i; q = q1[0]; r = r1[0]; e = err1;
      end
      if (i == 1) start1 = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy8, done8, err8} !== 3'b000) begin errors++; $display("FAIL reset8_flags: got %b expected 000", {busy8, done8, err8}); end
    checks++; if (q8 !== 8'd0) begin errors++; $display("FAIL reset8_q: got %0d expected 0", q8); end
    checks++; if (r8 !== 8'd0) begin errors++; $display("FAIL reset8_r: got %0d expected 0", r8); end
    checks++; if ({busy1, done1, err1} !== 3'b000) begin errors++; $display("FAIL reset1_flags: got %b expected 000", {busy1, done1, err1}); end
    checks++; if ({q1, r1} !== 2'b00) begin errors++; $display("FAIL reset1_qr: got %b expected 00", {q1, r1}); end
    rst = 1'b0;
  endtask

  task automatic test_width1_table;
    logic q, r, e, eq, er, ee;
    int lat, el;
    for (int k = 0; k < 4; k++) begin
      logic a, b;
      a = k[1]; b = k[0];
      ee = (b == 1'b0);
`ifdef DIVISION_ZERO_SAT_EN
      eq = ee ? 1'b1 : a;
`else
      eq = ee ? 1'b0 : a;
`endif
      er = ee ? a : 1'b0;
      el = ee ? 1 : 2;
      run1(a, b, q, r, e, lat);
      checks++; if (e !== ee) begin errors++; $display("FAIL w1_err %0d/%0d: got %b expected %b", a, b, e, ee); end
      checks++; if ({q, r} !== {eq, er}) begin errors++; $display("FAIL w1_qr %0d/%0d: got q=%b r=%b expected q=%b r=%b", a, b, q, r, eq, er); end
      checks++; if (lat !== el) begin errors++; $display("FAIL w1_latency %0d/%0d: got %0d expected %0d", a, b, lat, el); end
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] q, r, eq, er;
    logic e, ee, held;
    int lat, bn, dn;
    run8(8'd200, 8'd7, q, r, e, lat, bn, dn, held);
    checks++; if ({q, r, e} !== {8'd28, 8'd4, 1'b0}) begin errors++; $display("FAIL div_200_7: got q=%0d r=%0d e=%b expected q=28 r=4 e=0", q, r, e); end
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL div_200_7_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (bn !== W) begin errors++; $display("FAIL div_200_7_busy_cycles: got %0d expected %0d", bn, W); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL div_200_7_done_pulses: got %0d expected 1", dn); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_200_7_held: got q=%0d r=%0d expected q=28 r=4", q8, r8); end
    model8(8'd13, 8'd0, eq, er, ee);
    run8(8'd13, 8'd0, q, r, e, lat, bn, dn, held);
    checks++; if ({q, r, e} !== {eq, er, ee}) begin errors++; $display("FAIL div_13_0: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b", q, r, e, eq, er, ee); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_13_0_latency: got %0d expected 1", lat); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL div_13_0_busy_cycles: got %0d expected 0", bn); end
  endtask

  task automatic test_start_while_busy;
    int lat = 0, dn = 0, bn = 0;
    logic [W-1:0] q = '0, r = '0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd16;
    @(posedge clk);
    for (int i = 1; i <= W + 14; i++) begin
      @(negedge clk);
      if (busy8) bn++;
      if (done8) begin
        dn++;
        if (lat == 0) begin lat = i; q = q8; r = r8; end
      end
      start8 = (i == 3);
      if (i == 3) begin a8 = 8'd9; b8 = 8'd3; end
    end
    checks++; if ({q, r} !== {8'd15, 8'd15}) begin errors++; $display("FAIL busy_ignore_result: got q=%0d r=%0d expected q=15 r=15", q, r); end
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (dn !== 1 || bn !== W) begin errors++; $display("FAIL busy_ignore_count: got done=%0d busy=%0d expected done=1 busy=%0d", dn, bn, W); end
  endtask

  task automatic test_reset_mid_op;
    logic [W-1:0] q, r;
    logic e, held;
    int lat, bn, dn;
    int late_done = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd3;
    @(posedge clk);
    for (int i = 1; i <= W + 10; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (i == 4) rst = 1'b1;
      if (i == 5) begin
        rst = 1'b0;
        checks++; if ({busy8, done8, err8, q8, r8} !== '0) begin errors++; $display("FAIL reset_mid_outputs: got busy=%b done=%b err=%b q=%0d r=%0d expected all 0", busy8, done8, err8, q8, r8); end
      end
      if (i > 5 && done8) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", late_done); end
    run8(8'd100, 8'd3, q, r, e, lat, bn, dn, held);
    checks++; if ({q, r, e} !== {8'd33, 8'd1, 1'b0}) begin errors++; $display("FAIL after_reset_100_3: got q=%0d r=%0d e=%b expected q=33 r=1 e=0", q, r, e); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] a, b, c, d, qa, ra, qc, rc;
      logic ea, ec;
      int seen = 0, lat = 0;
      a = W'($urandom); b = W'($urandom_range(1, 255));
      c = W'($urandom); d = W'($urandom_range(1, 255));
      model8(a, b, qa, ra, ea);
      model8(c, d, qc, rc, ec);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b;
      @(posedge clk);
      for (int i = 1; i <= W + 4 && seen == 0; i++) begin
        @(negedge clk);
        start8 = 1'b0;
        if (done8) seen = 1;
      end
      checks++; if (seen == 0 || {q8, r8} !== {qa, ra}) begin errors++; $display("FAIL b2b_first %0d/%0d: got done=%0d q=%0d r=%0d expected q=%0d r=%0d", a, b, seen, q8, r8, qa, ra); end
      start8 = 1'b1; a8 = c; b8 = d;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom);
      checks++; if (busy8 !== 1'b1 || {q8, r8} !== {qa, ra}) begin errors++; $display("FAIL b2b_hold: got busy=%b q=%0d r=%0d expected busy=1 q=%0d r=%0d", busy8, q8, r8, qa, ra); end
      for (int i = 2; i <= W + 4 && lat == 0; i++) begin
        @(negedge clk);
        if (done8) lat = i;
      end
      checks++; if (lat != W + 1 || {q8, r8, err8} !== {qc, rc, ec}) begin errors++; $display("FAIL b2b_second %0d/%0d: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d", c, d, lat, q8, r8, W + 1, qc, rc); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b, q, r, eq, er;
      logic e, ee, held;
      int lat, bn, dn;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      model8(a, b, eq, er, ee);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      run8(a, b, q, r, e, lat, bn, dn, held);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      checks++; if ({q, r, e} !== {eq, er, ee}) begin errors++; $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b", a, b, q, r, e, eq, er, ee); end
      checks++; if (lat != ((b == 0) ? 1 : W + 1) || dn != 1) begin errors++; $display("FAIL rand_timing %0d/%0d: got lat=%0d pulses=%0d expected lat=%0d pulses=1", a, b, lat, dn, (b == 0) ? 1 : W + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_width1_table();
    test_directed();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/division.md
# division

Sequential unsigned integer divider with divide-by-zero detection, used wherever the datapath needs a quotient and remainder from two operands of the same width. It uses restoring division, one quotient bit per clock. The 1-bit configuration (WIDTH=1) gives the single-bit divide truth table, with the divide-by-zero result marked by an error flag. The block sits in the arithmetic unit behind a simple start/done handshake.

## Interface
- WIDTH, default 8: operand, quotient and remainder width in bits. Legal range is ≥1.
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request a division. Accepted only when o_busy=0.
- i_dividend  input  WIDTH  unsigned dividend. Sampled on the accepting edge.
- i_divisor  input  WIDTH  unsigned divisor. Sampled on the accepting edge.
- o_busy  output  1  high while a division is in progress (CALC state).
- o_done  output  1  one-cycle pulse when the result is valid.
- o_quotient  output  WIDTH  unsigned quotient. Held until the next accepted start.
- o_remainder  output  WIDTH  unsigned remainder. Held until the next accepted start.
- o_error  output  1  high when the last division had divisor = 0. Held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, with i_start=1 and i_divisor≠0:
  - Latch the operands, clear the partial remainder and the bit counter.
  - Clear o_error, go to CALC.
- IDLE, with i_start=1 and i_divisor=0:
  - o_error←1, o_quotient←0, o_remainder←i_dividend.
  - Go to DONE directly; CALC is skipped.
- CALC, each cycle:
  - Shift the next dividend MSB into the partial remainder (WIDTH+1 bits wide).
  - If partial remainder ≥ divisor: subtract the divisor and set the quotient bit to 1. Otherwise set the quotient bit to 0.
  - After WIDTH iterations, write o_quotient and o_remainder and go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. i_start is also accepted in DONE, with the same behaviour as in IDLE.
- i_start while o_busy=1 is ignored. The operation in progress is not disturbed.
- Results always satisfy dividend = quotient·divisor + remainder, with remainder < divisor, for every divisor ≠ 0.
- No signed mode and no rounding; the arithmetic is pure unsigned truncation.

## Timing
- Reset: every output is 0 (o_busy, o_done, o_quotient, o_remainder, o_error); state is IDLE.
- Reset mid-operation aborts the division: no o_done pulse, outputs cleared on the reset edge.
- Reset has priority over i_start in the same cycle.
- Normal division, with the accepting edge at cycle 0:
  - o_busy is high during cycles 1..WIDTH.
  - Results are valid and o_done=1 at cycle WIDTH+1.
  - Latency is WIDTH+1 cycles.
- Divide-by-zero: o_done=1 and o_error=1 at cycle 1, so latency is 1 cycle. o_busy never rises.
- Back-to-back operation: i_start high during the o_done cycle starts the next operation. The previous results stay visible until the new ones are written.
- Operand inputs may change freely after the accepting edge.

## Configuration
- DIVISION_ZERO_SAT_EN: controls the divide-by-zero result values.
- Defined: a divide-by-zero sets o_quotient to all ones (2^WIDTH−1) and o_remainder to the dividend.
- Undefined (default): a divide-by-zero sets o_quotient to 0 and o_remainder to the dividend.
- o_error and the timing are identical in both builds.

## Test plan
- WIDTH=1, each case one start followed by a wait for o_done:
  - 0/0 → o_error=1.
  - 0/1 → q=0, o_error=0.
  - 1/0 → o_error=1.
  - 1/1 → q=1, o_error=0.
- WIDTH=8, 200/7 → q=28, r=4, o_error=0, o_done exactly 9 cycles after the accepting edge.
- WIDTH=8, 13/0 → o_error=1, r=13, o_done 1 cycle after start. q=0, or q=255 with DIVISION_ZERO_SAT_EN.
- WIDTH=8, start 255/16, then pulse i_start with 9/3 while busy → q=15, r=15; the second request is ignored.
- WIDTH=8, assert i_rst at cycle 4 of 100/3 → all outputs 0, no o_done pulse. A following 100/3 → q=33, r=1.
